// File: rtl/button_press_decoder_if.sv
// Signal bundle between the input conditioner and the press decoder.
// The master drives the conditioned button level and edge pulses; the slave returns classified events.
interface button_press_decoder_if;
   logic       conditioned;
   logic       rising;
   logic       falling;
   logic       short_press;
   logic       long_press;
   logic       double_click;
   logic       held;
   logic       busy;
   logic [7:0] event_count;

   modport master (
      output conditioned, rising, falling,
      input  short_press, long_press, double_click, held, busy, event_count
   );

   modport slave (
      input  conditioned, rising, falling,
      output short_press, long_press, double_click, held, busy, event_count
   );
endinterface

// File: rtl/button_press_decoder.sv
// Classifies conditioned button activity into short press, long press and double click events.
// Every output is a register; pulses appear on the edge after the deciding sample.
module button_press_decoder #(
   parameter int unsigned LONG_T = 8,
   parameter int unsigned GAP_T  = 6,
   parameter int unsigned CW     = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   button_press_decoder_if.slave btn
);

   typedef enum logic [2:0] {
      StIdle,
      StPressed,
      StLongHeld,
      StWaitGap,
      StSecondPress
   } state_e;

   localparam logic [CW-1:0] LongLast = CW'(LONG_T - 1);
   localparam logic [CW-1:0] GapLast  = CW'(GAP_T - 1);

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          short_q, short_d;
   logic          long_q, long_d;
   logic          dbl_q, dbl_d;
   logic          held_q, held_d;
   logic          busy_q, busy_d;
   logic [7:0]    event_q, event_d;

   // Coincident edge pulses contradict each other, so both are discarded.
   logic rise, fall;
   assign rise = btn.rising & ~btn.falling;
   assign fall = btn.falling & ~btn.rising;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      short_d = 1'b0;
      long_d  = 1'b0;
      dbl_d   = 1'b0;
      case (state_q)
         StIdle: begin
            if (rise) begin
               state_d = StPressed;
               cnt_d   = '0;
            end
         end
         StPressed: begin
            if (fall) begin
               state_d = StWaitGap;
               cnt_d   = '0;
            end else if (cnt_q == LongLast) begin
               long_d  = 1'b1;
               state_d = StLongHeld;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         StLongHeld: begin
            // A lost falling pulse must not strand the FSM while the button is up.
            if (fall || !btn.conditioned) begin
               state_d = StIdle;
               cnt_d   = '0;
            end
         end
         StWaitGap: begin
            if (rise) begin
               state_d = StSecondPress;
               cnt_d   = '0;
            end else if (cnt_q == GapLast) begin
               short_d = 1'b1;
               state_d = StIdle;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         StSecondPress: begin
            if (fall) begin
               dbl_d   = 1'b1;
               state_d = StIdle;
               cnt_d   = '0;
            end else if (cnt_q == LongLast) begin
               long_d  = 1'b1;
               state_d = StLongHeld;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
      endcase
      held_d  = (state_d == StLongHeld);
      busy_d  = (state_d != StIdle);
      event_d = event_q + 8'(short_d | long_d | dbl_d);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         short_q <= 1'b0;
         long_q  <= 1'b0;
         dbl_q   <= 1'b0;
         held_q  <= 1'b0;
         busy_q  <= 1'b0;
         event_q <= 8'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         short_q <= short_d;
         long_q  <= long_d;
         dbl_q   <= dbl_d;
         held_q  <= held_d;
         busy_q  <= busy_d;
         event_q <= event_d;
      end
   end

   assign btn.short_press  = short_q;
   assign btn.long_press   = long_q;
   assign btn.double_click = dbl_q;
   assign btn.held         = held_q;
   assign btn.busy         = busy_q;
   assign btn.event_count  = event_q;

endmodule

// File: doc/button_press_decoder.md
BUTTON_PRESS_DECODER -- requirements
Module: button_press_decoder

Interface
REQ-001 SHALL have parameter LONG_T, default 8: press duration in clock cycles that qualifies as a long press.
REQ-002 SHALL have parameter GAP_T, default 6: maximum release-to-press gap in cycles that qualifies as a double click.
REQ-003 SHALL have parameter CW, default 16: internal cycle-counter width; LONG_T and GAP_T SHALL both be at most 2^CW-1.
REQ-004 SHALL have port clk, input, 1 bit: system clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port conditioned, input, 1 bit: debounced, synchronized button level from the input conditioner.
REQ-007 SHALL have port rising, input, 1 bit: one-cycle pulse from the input conditioner marking a 0->1 transition of conditioned.
REQ-008 SHALL have port falling, input, 1 bit: one-cycle pulse from the input conditioner marking a 1->0 transition of conditioned.
REQ-009 SHALL have port short_press, output, 1 bit: one-cycle pulse for a single short press.
REQ-010 SHALL have port long_press, output, 1 bit: one-cycle pulse when a press reaches LONG_T.
REQ-011 SHALL have port double_click, output, 1 bit: one-cycle pulse for two short presses within GAP_T.
REQ-012 SHALL have port held, output, 1 bit: level, high while a long press remains held.
REQ-013 SHALL have port busy, output, 1 bit: level, high whenever the FSM is not in IDLE.
REQ-014 SHALL have port event_count, output, 8 bits: count of classified events, wrapping modulo 256.

Function
REQ-015 SHALL implement a registered FSM with states IDLE, PRESSED, LONG_HELD, WAIT_GAP and SECOND_PRESS, plus one CW-bit cycle counter cnt.
REQ-016 In IDLE, a sampled rising SHALL cause a transition to PRESSED with cnt=0; other inputs SHALL be ignored.
REQ-017 In PRESSED, a sampled falling SHALL cause a transition to WAIT_GAP with cnt=0.
REQ-018 In PRESSED, if falling is not sampled and cnt==LONG_T-1, the block SHALL assert long_press for the next cycle and transition to LONG_HELD; otherwise cnt SHALL increment.
REQ-019 Consequently, long_press SHALL be high for exactly one cycle, starting LONG_T rising edges after the edge that sampled rising.
REQ-020 In LONG_HELD, held SHALL be 1; a sampled falling SHALL return the FSM to IDLE and drop held on that edge.
REQ-021 In WAIT_GAP, a sampled rising SHALL cause a transition to SECOND_PRESS with cnt=0.
REQ-022 In WAIT_GAP, if rising is not sampled and cnt==GAP_T-1, the block SHALL assert short_press for one cycle and return to IDLE; otherwise cnt SHALL increment.
REQ-023 In SECOND_PRESS, a sampled falling SHALL assert double_click for one cycle and return to IDLE.
REQ-024 In SECOND_PRESS, reaching cnt==LONG_T-1 without falling SHALL assert long_press and transition to LONG_HELD; no short_press or double_click SHALL be emitted for that sequence.
REQ-025 At most one of short_press, long_press and double_click SHALL be high in any cycle.
REQ-026 event_count SHALL increment by 1 on the edge that asserts any of short_press, long_press or double_click, wrapping from 255 to 0.
REQ-027 If rising and falling are sampled high in the same cycle, both SHALL be ignored and the state SHALL still advance on cnt only.
REQ-028 A rising sampled outside IDLE and WAIT_GAP, or a falling sampled in IDLE or WAIT_GAP, SHALL be ignored.
REQ-029 The conditioned input SHALL be used only as a qualifier: when leaving LONG_HELD, the FSM SHALL also return to IDLE if conditioned==0 even without a falling pulse.
REQ-030 All outputs SHALL be driven directly from registers, with no combinational path from inputs.

Reset
REQ-031 While rst_n==0, asynchronously and independently of clk: state=IDLE, cnt=0, short_press=long_press=double_click=held=busy=0, event_count=0.
REQ-032 Reset asserted mid-sequence SHALL discard the in-progress classification; no pulse SHALL be emitted after rst_n deasserts.
REQ-033 After rst_n deasserts, the first rising sampled SHALL be decoded normally.

Verification (LONG_T=8, GAP_T=6)
REQ-034 Rising at edge 0, falling at edge 3, no further edges -> short_press high for exactly one cycle after edge 9; event_count=1.
REQ-035 Rising at edge 0 held -> long_press high after edge 8 and held=1 from edge 8; falling at edge 20 -> held=0 after edge 20; event_count=1.
REQ-036 Rising at 0, falling at 2, rising at 5, falling at 7 -> double_click one cycle after edge 7; no short_press; event_count=1.
REQ-037 Rising at 0, falling at 2, rising at 5 held -> long_press after edge 13, with no double_click.
REQ-038 rst_n pulsed low at edge 4 of REQ-034's sequence -> all outputs 0 and no short_press thereafter; 256 short presses -> event_count wraps to 0.
